bin2bcd_sequencer: RTL and testbench

BIN2BCD_SEQUENCER -- requirements
Module: bin2bcd_sequencer

---
 rtl/bin2bcd_sequencer.sv | 102 ++++++++++
 tb/tb_bin2bcd_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_sequencer.sv
// bin2bcd_sequencer: multi-cycle double-dabble binary to BCD converter with valid/ready handshakes
// Ports: Clk, Reset (sync, active-high); Input/InValid/InReady operand handshake;
//        Output[0:3] is the most significant digit, OutValid/OutReady result handshake;
//        Busy high while converting; Overflow reports operand > 10^digits-1.
// Optional: define BIN2BCD_SEQUENCER_OVERFLOW_EN to build the overflow detector (else Overflow=0).
module bin2bcd_sequencer #(
  parameter int INPUT_BIT_WIDTH = 8,
  parameter int OUTPUT_DIGITS_COUNT = 3
) (
  input  logic                                Clk,
  input  logic                                Reset,
  input  logic [INPUT_BIT_WIDTH-1:0]          Input,
  input  logic                                InValid,
  output logic                                InReady,
  output logic [0:OUTPUT_DIGITS_COUNT*4-1]    Output,
  output logic                                OutValid,
  input  logic                                OutReady,
  output logic                                Busy,
  output logic                                Overflow
);
  localparam int W = INPUT_BIT_WIDTH;
  localparam int DW = 4 * OUTPUT_DIGITS_COUNT;
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
  state_t r_state;
  logic [W-1:0] r_sh;
  logic [DW-1:0] r_dig, r_out, w_adj, w_next;
  logic [CW-1:0] r_cnt;
  logic r_in_ready, r_out_valid, r_busy, w_last;
  for (genvar d = 0; d < OUTPUT_DIGITS_COUNT; d++) begin : g_adj
    assign w_adj[4*d +: 4] = r_dig[4*d +: 4] >= 4'd5 ? r_dig[4*d +: 4] + 4'd3 : r_dig[4*d +: 4];
  end
  // top bit of the adjusted chain falls off; operand MSB enters the bottom
  assign w_next = {w_adj[DW-2:0], r_sh[W-1]};
  assign w_last = r_cnt == CW'(1);
  assign InReady = r_in_ready;
  assign OutValid = r_out_valid;
  assign Busy = r_busy;
  assign Output = r_out;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_sh <= '0;
      r_dig <= '0;
      r_cnt <= '0;
      r_out <= '0;
      r_in_ready <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (InValid) begin
          r_state <= CONVERT;
          r_sh <= Input;
          r_dig <= '0;
          r_cnt <= CW'(W);
          r_in_ready <= 1'b0;
          r_busy <= 1'b1;
        end
        CONVERT: begin
          r_sh <= r_sh << 1;
          r_dig <= w_next;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_state <= DONE;
            r_out <= w_next;
            r_busy <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        DONE: if (OutReady) begin
          r_state <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef BIN2BCD_SEQUENCER_OVERFLOW_EN
  logic r_flag, r_ovf, w_ovf;
  logic [OUTPUT_DIGITS_COUNT-1:0] w_big;
  for (genvar d = 0; d < OUTPUT_DIGITS_COUNT; d++) begin : g_big
    assign w_big[d] = w_next[4*d +: 4] > 4'd9;
  end
  assign w_ovf = r_flag | w_adj[DW-1] | (|w_big);
  assign Overflow = r_ovf;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_flag <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_flag <= r_state == IDLE && InValid ? 1'b0 : r_state == CONVERT ? r_flag | w_adj[DW-1] : r_flag;
      r_ovf <= r_state == CONVERT && w_last ? w_ovf : r_state == DONE && OutReady ? 1'b0 : r_ovf;
    end
  end
`else
  logic w_unused;
  assign w_unused = w_adj[DW-1];
  assign Overflow = 1'b0;
`endif
endmodule

// File: tb/tb_bin2bcd_sequencer.sv
// tb_bin2bcd_sequencer: directed + random checks of two converter instances (3 and 2 digits) on shared inputs
module tb_bin2bcd_sequencer;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic [7:0] in_data;
  logic in_ready3, out_valid3, busy3, ovf3;
  logic in_ready2, out_valid2, busy2, ovf2;
  logic [0:11] out3;
  logic [0:7] out2;
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int v, got, n;
  int t[2];
  int ops[2];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  bin2bcd_sequencer #(.INPUT_BIT_WIDTH(8), .OUTPUT_DIGITS_COUNT(3)) u3 (
    .Clk(clk), .Reset(rst), .Input(in_data), .InValid(in_valid), .InReady(in_ready3),
    .Output(out3), .OutValid(out_valid3), .OutReady(out_ready), .Busy(busy3), .Overflow(ovf3));
  bin2bcd_sequencer #(.INPUT_BIT_WIDTH(8), .OUTPUT_DIGITS_COUNT(2)) u2 (
    .Clk(clk), .Reset(rst), .Input(in_data), .InValid(in_valid), .InReady(in_ready2),
    .Output(out2), .OutValid(out_valid2), .OutReady(out_ready), .Busy(busy2), .Overflow(ovf2));
  // reference: decimal digits of (v mod 10^d), packed one nibble per digit, MSD highest
  function automatic logic [31:0] bcd(input int val, input int d);
    int p = 1;
    int r;
    logic [31:0] res = '0;
    for (int i = 0; i < d; i++) p = p * 10;
    r = val % p;
    for (int i = 0; i < d; i++) begin
      res = res | (32'(r % 10) << (4 * i));
      r = r / 10;
    end
    return res;
  endfunction
  function automatic logic [31:0] ovf_exp(input int val, input int d);
    int p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
`ifdef BIN2BCD_SEQUENCER_OVERFLOW_EN
    return {31'd0, val >= p};
`else
    return {31'd0, 1'b0 & (val >= p)};
`endif
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic convert(input int val);
    int k = 0;
    @(negedge clk);
    in_data = 8'(val);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_after_load", busy3, 1);
    check("inready_after_load", in_ready3, 0);
    while (!out_valid3 && k < 20) begin
      @(negedge clk);
      k++;
    end
    // visible after edge 8, so first sampled high at edge 9
    check("latency_edges", k, 8);
    check("out3", out3, bcd(val, 3));
    check("ovf3", ovf3, ovf_exp(val, 3));
    check("out2", out2, bcd(val, 2));
    check("ovf2", ovf2, ovf_exp(val, 2));
    check("valid2", out_valid2, 1);
    check("busy_done", busy3, 0);
    check("inready_done", in_ready3, 0);
  endtask
  task automatic handshake(input int val);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_after_hs", out_valid3, 0);
    check("inready_after_hs", in_ready3, 1);
    check("busy_after_hs", busy3, 0);
    check("ovf_after_hs", ovf3, 0);
    check("out3_kept", out3, bcd(val, 3));
    check("out2_kept", out2, bcd(val, 2));
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_inready", in_ready3, 1);
    check("rst_valid", out_valid3, 0);
    check("rst_busy", busy3, 0);
    check("rst_ovf", ovf3, 0);
    check("rst_out", out3, 0);
    convert(255);
    handshake(255);
    convert(0);
    handshake(0);
    convert(99);
    handshake(99);
    convert(200);
    handshake(200);
    convert(42);
    handshake(42);
    convert(123);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 8'($urandom);
      @(negedge clk);
      check("bp_out", out3, bcd(123, 3));
      check("bp_inready", in_ready3, 0);
      check("bp_valid", out_valid3, 1);
      check("bp_busy", busy3, 0);
    end
    in_valid = 1'b0;
    handshake(123);
    @(negedge clk);
    in_data = 8'd77;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_inready", in_ready3, 1);
    check("midrst_busy", busy3, 0);
    check("midrst_valid", out_valid3, 0);
    check("midrst_out", out3, 0);
    convert(123);
    handshake(123);
    for (int i = 0; i < 20; i++) begin
      v = int'($urandom_range(0, 255));
      convert(v);
      handshake(v);
    end
    ops[0] = 17;
    ops[1] = 250;
    t[0] = 0;
    t[1] = 0;
    got = 0;
    n = 0;
    @(negedge clk);
    in_data = 8'd17;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (got < 2 && n < 40) begin
      @(negedge clk);
      n++;
      if (out_valid3) begin
        t[got] = cyc;
        check(got == 0 ? "b2b_first" : "b2b_second", out3, bcd(ops[got], 3));
        got++;
        in_data = 8'd250;
      end
    end
    check("b2b_count", got, 2);
    check("b2b_interval", t[1] - t[0], 10);
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
